// File: rtl/fifo_read_arbiter.sv
// Round-robin arbiter sharing one FIFO read port among four requesters.
// Define FIFO_READ_ARBITER_STICKY_UNDERFLOW_EN to make underflow sticky until reset.
module fifo_read_arbiter #(
  parameter int DATA_W = 8,
  parameter int PTR_W  = 5,
  parameter int N_REQ  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_REQ-1:0]  req,
  input  logic [PTR_W:0]    fifo_count,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd_en,
  output logic [PTR_W-1:0]  fifo_rd_ptr,
  output logic [N_REQ-1:0]  gnt,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              underflow
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    CAPTURE
  } state_t;

  state_t            state, state_n;
  logic [PTR_W-1:0]  ptr, ptr_n;
  logic [1:0]        last_gnt, last_n;
  logic [1:0]        win;
  logic [1:0]        idx;
  logic [N_REQ-1:0]  gnt_n;
  logic [PTR_W-1:0]  rd_ptr_n;
  logic [DATA_W-1:0] rd_data_n;
  logic              rd_en_n;
  logic              rd_valid_n;
  logic              uf_cond;
  logic              uf_n;

  // Scan from farthest to nearest so the first requester after last_gnt wins.
  always_comb begin
    win = last_gnt;
    idx = last_gnt;
    for (int i = N_REQ; i >= 1; i--) begin
      idx = last_gnt + 2'(i);
      if (req[idx]) win = idx;
    end
  end

  always_comb begin
    state_n    = state;
    ptr_n      = ptr;
    last_n     = last_gnt;
    gnt_n      = gnt;
    rd_en_n    = 1'b0;
    rd_ptr_n   = fifo_rd_ptr;
    rd_valid_n = 1'b0;
    rd_data_n  = rd_data;
    uf_cond    = 1'b0;
    unique case (state)
      IDLE: begin
        gnt_n = '0;
        if (|req) begin
          if (fifo_count != '0) begin
            gnt_n    = N_REQ'(1) << win;
            rd_en_n  = 1'b1;
            rd_ptr_n = ptr;
            ptr_n    = ptr + PTR_W'(1);
            last_n   = win;
            state_n  = ISSUE;
          end else begin
            uf_cond = 1'b1;
          end
        end
      end
      ISSUE:   state_n = WAIT;
      WAIT:    state_n = CAPTURE;
      CAPTURE: begin
        rd_data_n  = fifo_data;
        rd_valid_n = 1'b1;
        state_n    = IDLE;
      end
      default: state_n = IDLE;
    endcase
`ifdef FIFO_READ_ARBITER_STICKY_UNDERFLOW_EN
    uf_n = underflow | uf_cond;
`else
    uf_n = uf_cond;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      ptr         <= '0;
      last_gnt    <= 2'd3;
      gnt         <= '0;
      fifo_rd_en  <= 1'b0;
      fifo_rd_ptr <= '0;
      rd_valid    <= 1'b0;
      rd_data     <= '0;
      underflow   <= 1'b0;
    end else begin
      state       <= state_n;
      ptr         <= ptr_n;
      last_gnt    <= last_n;
      gnt         <= gnt_n;
      fifo_rd_en  <= rd_en_n;
      fifo_rd_ptr <= rd_ptr_n;
      rd_valid    <= rd_valid_n;
      rd_data     <= rd_data_n;
      underflow   <= uf_n;
    end
  end

endmodule

// File: tb/tb_fifo_read_arbiter.sv
// Directed self-checking bench for fifo_read_arbiter.
// Expected values are hand-derived from the block's timing contract.
module tb_fifo_read_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic [5:0] fifo_count;
  logic [7:0] fifo_data;
  logic       fifo_rd_en;
  logic [4:0] fifo_rd_ptr;
  logic [3:0] gnt;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       underflow;

  int n_tests = 0;
  int n_fail  = 0;

  fifo_read_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .fifo_count  (fifo_count),
    .fifo_data   (fifo_data),
    .fifo_rd_en  (fifo_rd_en),
    .fifo_rd_ptr (fifo_rd_ptr),
    .gnt         (gnt),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .underflow   (underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until a read strobe appears; n is the cycles waited.
  task automatic wait_rd(input string tag, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!fifo_rd_en && n < 16);
    if (!fifo_rd_en) check({tag, "_timeout"}, 32'(0), 32'(1));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic check_idle_outs(input string tag);
    check({tag, "_gnt"},   32'(gnt),         32'(0));
    check({tag, "_rden"},  32'(fifo_rd_en),  32'(0));
    check({tag, "_ptr"},   32'(fifo_rd_ptr), 32'(0));
    check({tag, "_vld"},   32'(rd_valid),    32'(0));
    check({tag, "_data"},  32'(rd_data),     32'(0));
    check({tag, "_uf"},    32'(underflow),   32'(0));
  endtask

  logic [3:0] rr_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  initial begin
    int n;
    reset      = 1'b1;
    req        = '0;
    fifo_count = '0;
    fifo_data  = '0;
    #2;
    check_idle_outs("reset");
    tick();
    reset = 1'b0;

    // Single read: latency and data capture
    req        = 4'b0001;
    fifo_count = 6'd5;
    fifo_data  = 8'hA5;
    tick();
    check("r1_gnt",  32'(gnt),         32'(4'b0001));
    check("r1_rden", 32'(fifo_rd_en),  32'(1));
    check("r1_ptr",  32'(fifo_rd_ptr), 32'(0));
    req = '0;
    tick();
    check("r1_rden_pulse", 32'(fifo_rd_en), 32'(0));
    check("r1_gnt_hold",   32'(gnt),        32'(4'b0001));
    tick();
    check("r1_novld", 32'(rd_valid), 32'(0));
    tick();
    check("r1_vld",      32'(rd_valid), 32'(1));
    check("r1_data",     32'(rd_data),  32'(8'hA5));
    check("r1_gnt_last", 32'(gnt),      32'(4'b0001));
    req = 4'b0001;
    tick();
    check("r2_rden", 32'(fifo_rd_en),  32'(1));
    check("r2_ptr",  32'(fifo_rd_ptr), 32'(1));
    check("r2_vld_pulse", 32'(rd_valid), 32'(0));
    req = '0;
    repeat (3) tick();
    check("r2_vld", 32'(rd_valid), 32'(1));
    tick();
    check("idle_gnt",  32'(gnt),        32'(0));
    check("idle_rden", 32'(fifo_rd_en), 32'(0));

    // Round-robin with all requesting
    do_reset();
    req        = 4'b1111;
    fifo_count = 6'd20;
    for (int k = 0; k < 5; k++) begin
      wait_rd("rr", n);
      check($sformatf("rr%0d_gnt", k), 32'(gnt), 32'(rr_exp[k]));
      if (k > 0) check($sformatf("rr%0d_gap", k), 32'(n), 32'(4));
    end
    req = '0;
    repeat (4) tick();

    // Underflow, then recovery when data arrives
    do_reset();
    req        = 4'b0100;
    fifo_count = '0;
    tick();
    check("uf_set",  32'(underflow),  32'(1));
    check("uf_rden", 32'(fifo_rd_en), 32'(0));
    check("uf_gnt",  32'(gnt),        32'(0));
    tick();
    check("uf_ptr_held", 32'(fifo_rd_ptr), 32'(0));
    fifo_count = 6'd1;
    tick();
`ifdef FIFO_READ_ARBITER_STICKY_UNDERFLOW_EN
    check("uf_after", 32'(underflow), 32'(1));
`else
    check("uf_after", 32'(underflow), 32'(0));
`endif
    check("uf_rd_rden", 32'(fifo_rd_en),  32'(1));
    check("uf_rd_gnt",  32'(gnt),         32'(4'b0100));
    check("uf_rd_ptr",  32'(fifo_rd_ptr), 32'(0));
    req = '0;
    repeat (3) tick();
    check("uf_rd_vld", 32'(rd_valid), 32'(1));
    tick();

    // Pointer wrap over 33 reads
    do_reset();
    req        = 4'b0001;
    fifo_count = 6'd10;
    for (int k = 0; k < 33; k++) begin
      wait_rd("wrap", n);
      check($sformatf("wrap%0d_ptr", k), 32'(fifo_rd_ptr), 32'(k % 32));
    end
    req = '0;
    repeat (4) tick();

    // Reset in WAIT; pointer and priority restart
    req = 4'b1111;
    tick();
    check("rw_gnt", 32'(gnt),         32'(4'b0010));
    check("rw_ptr", 32'(fifo_rd_ptr), 32'(1));
    tick();
    reset = 1'b1;
    #1;
    check("rw_gnt0",  32'(gnt),         32'(0));
    check("rw_ptr0",  32'(fifo_rd_ptr), 32'(0));
    check("rw_vld0",  32'(rd_valid),    32'(0));
    check("rw_rden0", 32'(fifo_rd_en),  32'(0));
    tick();
    reset = 1'b0;
    tick();
    check("rw_new_gnt", 32'(gnt),         32'(4'b0001));
    check("rw_new_ptr", 32'(fifo_rd_ptr), 32'(0));
    check("rw_new_vld", 32'(rd_valid),    32'(0));
    req = '0;
    repeat (4) tick();

    // Request dropped after issue still completes
    do_reset();
    req        = 4'b0010;
    fifo_count = 6'd4;
    fifo_data  = 8'h3C;
    tick();
    check("drop_gnt", 32'(gnt), 32'(4'b0010));
    req = '0;
    repeat (3) tick();
    check("drop_vld",  32'(rd_valid), 32'(1));
    check("drop_gnt2", 32'(gnt),      32'(4'b0010));
    check("drop_data", 32'(rd_data),  32'(8'h3C));
    tick();
    check("drop_clr", 32'(gnt), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_read_arbiter.md
FIFO_READ_ARBITER -- requirements
Module: fifo_read_arbiter

Interface
REQ-001 Parameter: DATA_W, 8, width of FIFO read data.
REQ-002 Parameter: PTR_W, 5, read pointer width (FIFO depth 2**PTR_W = 32).
REQ-003 Parameter: N_REQ, 4, number of requesters (fixed at 4 for this revision).
REQ-004 Port: clk, input, 1, single clock; all state updates on the rising edge.
REQ-005 Port: reset, input, 1, asynchronous, active-high; clears all state immediately.
REQ-006 Port: req, input, N_REQ, level request per requester.
REQ-007 Port: fifo_count, input, PTR_W+1, current FIFO occupancy in the range 0..32.
REQ-008 Port: fifo_data, input, DATA_W, FIFO read data, valid the cycle after the FIFO samples fifo_rd_en.
REQ-009 Port: fifo_rd_en, output, 1, one-cycle read strobe to the FIFO.
REQ-010 Port: fifo_rd_ptr, output, PTR_W, read address issued with fifo_rd_en.
REQ-011 Port: gnt, output, N_REQ, one-hot grant; all zero when idle.
REQ-012 Port: rd_valid, output, 1, one-cycle pulse marking rd_data valid for the granted requester.
REQ-013 Port: rd_data, output, DATA_W, captured read data.
REQ-014 Port: underflow, output, 1, request seen while FIFO empty.

Function
REQ-015 The FSM SHALL have four states, IDLE, ISSUE, WAIT and CAPTURE, with all outputs registered.
REQ-016 In IDLE, when |req=1 and fifo_count!=0, the block SHALL select a winner round-robin, starting the search at (last_gnt+1) mod 4, and go to ISSUE.
REQ-017 On entering ISSUE, the block SHALL set gnt to the winner's one-hot code, assert fifo_rd_en=1 for exactly one cycle, and drive fifo_rd_ptr with the internal pointer.
REQ-018 ISSUE SHALL go to WAIT. WAIT SHALL go to CAPTURE. On leaving CAPTURE, the block SHALL load rd_data with fifo_data, pulse rd_valid=1 for one cycle, and return to IDLE.
REQ-019 gnt SHALL stay stable from ISSUE through the rd_valid cycle, then clear, unless a new grant is issued in that same IDLE cycle.
REQ-020 Latency: req sampled in IDLE at cycle t gives gnt and fifo_rd_en at t+1 and rd_valid at t+4. Minimum spacing between fifo_rd_en strobes SHALL be 4 cycles.
REQ-021 The internal read pointer SHALL increment by 1 per issued read and wrap from 31 to 0.
REQ-022 last_gnt SHALL update to the winner index on each issued read only.
REQ-023 If req drops after ISSUE, the transaction SHALL still complete with rd_valid.
REQ-024 In IDLE, with |req=1 and fifo_count==0, the block SHALL set underflow=1, issue no read, leave the pointer and last_gnt unchanged, and remain in IDLE.
REQ-025 underflow SHALL be 0 in any cycle where its condition is not met, subject to REQ-030.
REQ-026 With req==0, the block SHALL remain in IDLE with fifo_rd_en=0 and gnt=0.

Reset
REQ-027 Asserting reset SHALL immediately force: state=IDLE, gnt=0, fifo_rd_en=0, fifo_rd_ptr=0, internal pointer=0, rd_valid=0, rd_data=0, underflow=0, last_gnt=3 (so req[0] has top priority first).
REQ-028 Reset asserted mid-transaction SHALL abandon the read with no rd_valid, and the pointer SHALL not advance.

Configuration
REQ-029 Macro FIFO_READ_ARBITER_STICKY_UNDERFLOW_EN SHALL select the underflow behaviour.
REQ-030 With the macro defined, underflow SHALL be sticky, set per REQ-024 and cleared only by reset. With it undefined, underflow SHALL be a per-cycle flag per REQ-025.

Verification
REQ-031 After reset, req=4'b0001, fifo_count=5, fifo_data=8'hA5 -> gnt=0001 and fifo_rd_en with fifo_rd_ptr=0 at t+1; rd_valid with rd_data=A5 at t+4; next read uses fifo_rd_ptr=1.
REQ-032 req=4'b1111 held, fifo_count=20 -> grants in the order 0001, 0010, 0100, 1000, 0001, with fifo_rd_en strobes 4 cycles apart.
REQ-033 req=4'b0100, fifo_count=0 -> underflow=1, fifo_rd_en=0, gnt=0; with fifo_count then 1 and the macro undefined -> underflow=0 and a read is issued; with the macro defined -> underflow remains 1.
REQ-034 Issue 33 reads with fifo_count>0 -> fifo_rd_ptr sequence runs 0..31 then 0.
REQ-035 Assert reset during WAIT -> all outputs 0 immediately, no rd_valid, and the next read uses fifo_rd_ptr=0 with req[0] having priority.
REQ-036 req=4'b0010 dropped the cycle after ISSUE -> rd_valid still pulses at t+4 with gnt=0010.
